// File: rtl/mux7_pkg.sv
// Shared constants and types for the 7-input mux round-robin scheduler.
package mux7_pkg;

    localparam int NUM_REQ = 7;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = $clog2(16);

    localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

endpackage

// File: rtl/rr_pick7.sv
// Combinational round-robin picker: finds the first set request bit,
// scanning upward from (last+1) mod 7 and wrapping 6 -> 0.
module rr_pick7
    import mux7_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [3:0] pos;

    // Walk the offsets from farthest to nearest so the nearest match is the one kept.
    always_comb begin
        any = 1'b0;
        idx = SEL_IDLE;
        pos = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = 4'(last) + 4'(k);
            if (pos >= 4'(NUM_REQ)) begin
                pos = pos - 4'(NUM_REQ);
            end
            if (pos < 4'(NUM_REQ) && req[pos[2:0]]) begin
                any = 1'b1;
                idx = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/mux7_rr_sched.sv
// Round-robin scheduler driving the select of a shared 7-to-1 mux.
// Each grant lasts up to HOLD_CYCLES cycles; sel parks on 3'b111 when idle.
module mux7_rr_sched
    import mux7_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  last;
    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic              release_now;

    rr_pick7 u_pick (
        .req  (req),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // The owner gives up the mux when it stops requesting or its hold budget is spent.
    always_comb begin
        release_now = 1'b0;
        if (state == ST_GRANT) begin
            release_now = !req[sel] || (cnt == '0);
        end
    end

    // Grant FSM with registered outputs; a release re-arbitrates on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= SEL_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            last  <= 3'd6;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state <= ST_GRANT;
                        sel   <= pick_idx;
                        grant <= 7'b1 << pick_idx;
                        busy  <= 1'b1;
                        cnt   <= CNT_LOAD;
                        last  <= pick_idx;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        if (pick_any) begin
                            sel   <= pick_idx;
                            grant <= 7'b1 << pick_idx;
                            cnt   <= CNT_LOAD;
                            last  <= pick_idx;
                        end else begin
                            state <= ST_IDLE;
                            sel   <= SEL_IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    sel   <= SEL_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux7_rr_sched.sv
// Bench for mux7_rr_sched: two instances (hold 4 and hold 1) share stimulus
// and are compared against a queue-free behavioural model of the grant rules.
module tb_mux7_rr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] req = '0;

    logic [2:0] sel4, sel1;
    logic [6:0] grant4, grant1;
    logic       busy4, busy1;

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = hold 4, index 1 = hold 1.
    int hold  [2] = '{4, 1};
    int m_own [2];
    int m_age [2];
    int m_last[2];

    mux7_rr_sched #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .sel(sel4), .grant(grant4), .busy(busy4)
    );

    mux7_rr_sched #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .sel(sel1), .grant(grant1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Next owner: first requester found going upward from the one after last.
    task automatic model_pick(input int i, input logic [6:0] r);
        bit found = 0;
        for (int k = 1; k <= 7; k++) begin
            int c = (m_last[i] + k) % 7;
            if (!found && r[c]) begin
                found     = 1;
                m_own[i]  = c;
                m_last[i] = c;
                m_age[i]  = 1;
            end
        end
    endtask

    task automatic model_edge(input int i, input logic [6:0] r, input logic rr);
        if (rr) begin
            m_own[i] = -1; m_age[i] = 0; m_last[i] = 6;
        end else if (m_own[i] < 0) begin
            if (r != 0) model_pick(i, r);
        end else if (!r[m_own[i]] || m_age[i] >= hold[i]) begin
            if (r != 0) model_pick(i, r);
            else m_own[i] = -1;
        end else begin
            m_age[i]++;
        end
    endtask

    function automatic logic [10:0] expv(input int i);
        if (m_own[i] < 0) return {3'b111, 7'b0, 1'b0};
        return {3'(m_own[i]), 7'(1 << m_own[i]), 1'b1};
    endfunction

    task automatic step(input logic [6:0] r);
        req = r;
        @(posedge clk);
        model_edge(0, r, rst);
        model_edge(1, r, rst);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(7'h00);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step(7'h7F);
            total++;
            if ({sel4, grant4, busy4} !== {3'b111, 7'b0, 1'b0}) begin
                bad++; $display("FAIL reset_h4 got=%h want=%h", {sel4, grant4, busy4}, {3'b111, 7'b0, 1'b0});
            end
            total++;
            if ({sel1, grant1, busy1} !== {3'b111, 7'b0, 1'b0}) begin
                bad++; $display("FAIL reset_h1 got=%h want=%h", {sel1, grant1, busy1}, {3'b111, 7'b0, 1'b0});
            end
        end
        rst = 1'b0;
        step(7'h7F);
        total++;
        if ({sel4, grant4, busy4} !== {3'd0, 7'b0000001, 1'b1}) begin
            bad++; $display("FAIL first_grant_h4 got=%h want=%h", {sel4, grant4, busy4}, {3'd0, 7'b0000001, 1'b1});
        end
        total++;
        if ({sel1, grant1, busy1} !== {3'd0, 7'b0000001, 1'b1}) begin
            bad++; $display("FAIL first_grant_h1 got=%h want=%h", {sel1, grant1, busy1}, {3'd0, 7'b0000001, 1'b1});
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(7'b0001000);
            total++;
            if ({sel4, grant4, busy4} !== {3'd3, 7'b0001000, 1'b1}) begin
                bad++; $display("FAIL single_held c=%0d got=%h want=%h", c, {sel4, grant4, busy4}, {3'd3, 7'b0001000, 1'b1});
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int c = 0; c < 32; c++) begin
            step(7'h7F);
            total++;
            if (sel4 !== 3'((c / 4) % 7) || grant4 !== 7'(1 << ((c / 4) % 7)) || busy4 !== 1'b1) begin
                bad++; $display("FAIL contention_h4 c=%0d got sel=%0d grant=%b want sel=%0d", c, sel4, grant4, (c / 4) % 7);
            end
            total++;
            if (sel1 !== 3'(c % 7) || grant1 !== 7'(1 << (c % 7))) begin
                bad++; $display("FAIL contention_h1 c=%0d got sel=%0d want sel=%0d", c, sel1, c % 7);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        step(7'b0000100);
        step(7'b0000100);
        req = 7'b0000000;
        #1;
        total++;
        if (sel4 !== 3'd2 || busy4 !== 1'b1) begin
            bad++; $display("FAIL early_drop_cycle got sel=%0d busy=%b want sel=2 busy=1", sel4, busy4);
        end
        step(7'b0000000);
        total++;
        if ({sel4, grant4, busy4} !== {3'b111, 7'b0, 1'b0}) begin
            bad++; $display("FAIL early_idle got=%h want=%h", {sel4, grant4, busy4}, {3'b111, 7'b0, 1'b0});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(7'b1000000);
        for (int c = 1; c < 20; c++) begin
            step(7'b1000001);
            total++;
            if (sel4 !== (((c / 4) % 2 == 0) ? 3'd6 : 3'd0)) begin
                bad++; $display("FAIL wrap c=%0d got sel=%0d want sel=%0d", c, sel4, ((c / 4) % 2 == 0) ? 6 : 0);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit seen = 0;
        do_reset();
        for (int c = 0; c < 40 && !seen; c++) begin
            step(7'h7F);
            if (sel4 == 3'd4) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL mid_reset_wait got sel=%0d want sel=4 within 40 cycles", sel4);
        end
        rst = 1'b1;
        step(7'h7F);
        rst = 1'b0;
        total++;
        if ({sel4, grant4, busy4} !== {3'b111, 7'b0, 1'b0}) begin
            bad++; $display("FAIL mid_reset got=%h want=%h", {sel4, grant4, busy4}, {3'b111, 7'b0, 1'b0});
        end
    endtask

    task automatic test_hold1_rotate();
        logic [2:0] seq [3] = '{3'd1, 3'd2, 3'd4};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            step(7'b0010110);
            total++;
            if (sel1 !== seq[c % 3] || busy1 !== 1'b1) begin
                bad++; $display("FAIL hold1_rotate c=%0d got sel=%0d want sel=%0d", c, sel1, seq[c % 3]);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0:       r = 7'($urandom);
                1:       r = 7'($urandom) & 7'($urandom) & 7'($urandom);
                2:       r = 7'(1 << $urandom_range(0, 6));
                default: r = req;
            endcase
            rst = ($urandom_range(0, 99) == 0);
            step(r);
            total++;
            if ({sel4, grant4, busy4} !== expv(0)) begin
                bad++; $display("FAIL random_h4 c=%0d got=%h want=%h", c, {sel4, grant4, busy4}, expv(0));
            end
            total++;
            if ({sel1, grant1, busy1} !== expv(1)) begin
                bad++; $display("FAIL random_h1 c=%0d got=%h want=%h", c, {sel1, grant1, busy1}, expv(1));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1; m_age[i] = 0; m_last[i] = 6;
        end
        test_reset();
        test_single();
        test_contention();
        test_early_release();
        test_wrap();
        test_mid_reset();
        test_hold1_rotate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux7_rr_sched.md
# mux7_rr_sched

Round-robin scheduler that shares the 7-to-1 single-bit mux between seven requesters. It arbitrates among `req[6:0]`, drives the mux `sel[2:0]`, and holds each grant for up to `HOLD_CYCLES` cycles. When no requester is granted it parks `sel` on the unused code `3'b111`. It sits directly in front of the `mux_7to1` instance and is its only source of `sel`.

## Interface
- `HOLD_CYCLES`, default 4: maximum consecutive cycles per grant; legal range 1..16.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 7: request per mux input; level-sensitive, held while the requester wants the mux.
- `sel` out 3: mux select; 0..6 while granted, `3'b111` when idle.
- `grant` out 7: one-hot grant, matching `sel`; all zeros when idle.
- `busy` out 1: high while a grant is active.

## Operation
- Reset values:
  - `sel=3'b111`, `grant=0`, `busy=0`.
  - state IDLE, hold counter 0.
  - last-granted pointer `last=6`, so the first search starts at index 0.
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the mux.
- Winner selection (combinational, registered on the edge):
  - Scan `req` starting at `(last+1) mod 7` and moving upward, wrapping 6→0.
  - The first set bit wins.
  - The current owner is therefore lowest priority at re-arbitration.
- IDLE → GRANT when `|req`:
  - Register the winner into `sel`/`grant`.
  - Set `busy=1`.
  - Load `cnt=HOLD_CYCLES-1` and set `last=winner`.
- GRANT, each cycle, with `cur` = owner:
  - Release when `req[cur]==0` or `cnt==0`.
  - If both conditions are true in the same cycle, release exactly once.
  - Otherwise decrement `cnt`.
- On release:
  - If any `req` bit is set (the current owner included, if it is still requesting), grant the next winner on the same edge. There is no idle gap, and `cnt` reloads.
  - If the releasing owner is the only requester, it is re-granted with `sel` unchanged.
  - If no requests remain: go to IDLE with `sel=3'b111`, `grant=0`, `busy=0`.
- `sel` never takes the value 7 while `busy=1`. `grant` is always one-hot or zero.
- `last` updates only when a grant is issued. It is unchanged through IDLE.
- `req` bits that rise mid-grant wait for the next release; they never pre-empt the owner.

## Timing
- Request-to-grant latency is one cycle: `req` sampled high at edge N (scheduler IDLE) → `sel`/`grant` valid after edge N.
- A held request owns the mux for exactly `HOLD_CYCLES` cycles when it stays asserted.
- Early release:
  - `req[cur]` observed low at edge N → the new grant, or IDLE, is visible after edge N.
  - The owner therefore keeps `sel` for the cycle in which it dropped `req`.
- `HOLD_CYCLES=1`: re-arbitration happens every cycle. With multiple requesters, `sel` rotates each cycle.
- Reset mid-grant: `rst` high at edge N forces the reset values after edge N, regardless of state or `req`. The first grant after reset goes to the lowest-indexed active requester.
- All outputs are registered; there are no combinational paths from `req` to any output.

## Structure
- Package `mux7_pkg` holds:
  - `NUM_REQ=7`
  - `SEL_W=3`
  - `SEL_IDLE=3'b111`
  - state enum `{ST_IDLE, ST_GRANT}`
  - counter width `CNT_W=$clog2(16)=4`
- Sub-module `rr_pick7`: combinational rotate-and-priority picker.
  - Inputs: `req[6:0]`, `last[2:0]`.
  - Outputs: `any`, `idx[2:0]`.
  - It is the natural unit test point for the wrap logic.
- The top module holds the FSM, hold counter, `last` register and output registers.

## Test plan
- Reset: `rst=1` for 2 cycles with `req=7'h7F` → `sel=3'b111`, `grant=0`, `busy=0` throughout. After `rst` falls, first grant is `sel=0`, `grant=7'b0000001`.
- Single requester held: `req=7'b0001000` continuously, `HOLD_CYCLES=4` → `sel=3`, `grant=7'b0001000`, `busy=1` from one cycle after the request. Holds continuously: re-granted at each 4-cycle boundary with no gap.
- Full contention: `req=7'h7F` from reset → `sel` sequence 0,1,2,3,4,5,6,0, each held exactly 4 cycles, no idle cycle, `grant` one-hot throughout.
- Early release:
  - Only `req[2]` asserted.
  - Drop it after 2 granted cycles.
  - Required: `sel=2` for the drop cycle, then `sel=3'b111`, `busy=0` on the next cycle.
- Wrap-around:
  - Grant to 6 completes with `req=7'b1000001` held.
  - Required: next grant `sel=0`, then `sel=6`, then `sel=0`, alternating every 4 cycles.
- Reset mid-grant and `HOLD_CYCLES=1`:
  - Assert `rst` during `sel=4` → reset values on the next cycle.
  - Separately, with `HOLD_CYCLES=1` and `req=7'b0010110`, `sel` rotates 1,2,4,1 every cycle.
